// File: rtl/data_ram_bank_xbar_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_bank_xbar_pkg
// Memory-map constants for the scratchpad data RAM and the address decode
// helper shared by the data-RAM bank crossbar.
//   DATA_RAM_START/END_ADDRESS : byte window of the data RAM (end exclusive)
//   RAM_BANK_SIZE              : bytes per bank (32 KiB)
//   NUM_DATA_BANKS/BANK_IDX_W  : bank count and bank index width
//   BANK_WORD_AW               : word address width inside one bank
//   dram_decode()              : absolute byte address -> {in_range, bank, word}
// -----------------------------------------------------------------------------
package data_ram_bank_xbar_pkg;

    localparam logic [31:0] DATA_RAM_START_ADDRESS = 32'h0000_8000;
    localparam logic [31:0] DATA_RAM_END_ADDRESS   = 32'h0002_8000;
    localparam logic [31:0] RAM_BANK_SIZE          = 32'h0000_8000;

    localparam int NUM_DATA_BANKS = 4;
    localparam int BANK_IDX_W     = 2;
    localparam int BANK_WORD_AW   = 13;

    typedef struct packed {
        logic                    in_range;
        logic [BANK_IDX_W-1:0]   bank;
        logic [BANK_WORD_AW-1:0] word;
    } dram_decode_t;

    // Bank and word come straight from the offset bits; the low two address
    // bits are byte lanes and are ignored. Bank/word are meaningless when
    // in_range is low.
    function automatic dram_decode_t dram_decode(input logic [31:0] addr);
        dram_decode_t res;
        logic [31:0]  off;
        off          = addr - DATA_RAM_START_ADDRESS;
        res.in_range = (addr >= DATA_RAM_START_ADDRESS) && (addr < DATA_RAM_END_ADDRESS);
        res.bank     = off[16:15];
        res.word     = off[14:2];
        return res;
    endfunction

endpackage

// File: rtl/data_ram_bank_xbar_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_rr_arbiter
// Round-robin arbiter for one data-RAM bank.
//   clk, reset : clock, asynchronous active-high reset (pointer -> lane 0)
//   req        : N-wide request vector (lanes targeting this bank)
//   gnt        : one-hot grant, combinational from req and the pointer
// The pointer names the highest-priority lane and moves to the lane after the
// winner only when a grant is issued.
// -----------------------------------------------------------------------------
module data_ram_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] idx_s;
    logic [PTR_W-1:0] pick_s;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic             any_s;

    // Grant selection: scan from lowest priority to highest so the last
    // requesting lane written is the one closest to the pointer.
    always_comb begin
        any_s  = |req;
        pick_s = '0;
        idx_s  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s  = PTR_W'((int'(ptr_r) + k) % N);
            pick_s = req[idx_s] ? idx_s : pick_s;
        end
        gnt       = any_s ? (N'(1) << pick_s) : '0;
        ptr_nxt_s = (int'(pick_s) == N - 1) ? '0 : (pick_s + PTR_W'(1));
    end

    // Priority pointer: advances past the winner, holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (any_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/data_ram_bank_xbar.sv
// -----------------------------------------------------------------------------
// data_ram_bank_xbar
// Request crossbar between the load/store lanes and the four data-RAM banks.
// Decodes each lane's byte address, arbitrates each bank round-robin, drives
// the bank SRAM ports and returns a 1-cycle response per accepted request.
//   clk, reset    : clock, asynchronous active-high reset
//   req_*_i       : per-lane request (valid, byte address, we, be, wdata)
//   req_ready_o   : request accepted this cycle (combinational)
//   rsp_valid_o   : response for the request accepted last cycle
//   rsp_err_o     : that request was outside the data RAM
//   rsp_rdata_o   : read data (0 for writes and errors)
//   bank_*_o      : per-bank SRAM strobe, we, word address, be, wdata
//   bank_rdata_i  : per-bank read data, one cycle after the strobe
// Out-of-range requests are accepted at once and answered with an error; they
// never touch a bank.
// -----------------------------------------------------------------------------
module data_ram_bank_xbar #(
    parameter int NUM_REQS     = 4,
    parameter int NUM_BANKS    = data_ram_bank_xbar_pkg::NUM_DATA_BANKS,
    parameter int DATA_W       = 32,
    parameter int BANK_WORD_AW = data_ram_bank_xbar_pkg::BANK_WORD_AW
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid_i,
    input  logic [NUM_REQS*32-1:0]            req_addr_i,
    input  logic [NUM_REQS-1:0]               req_we_i,
    input  logic [NUM_REQS*(DATA_W/8)-1:0]    req_be_i,
    input  logic [NUM_REQS*DATA_W-1:0]        req_wdata_i,
    output logic [NUM_REQS-1:0]               req_ready_o,
    output logic [NUM_REQS-1:0]               rsp_valid_o,
    output logic [NUM_REQS-1:0]               rsp_err_o,
    output logic [NUM_REQS*DATA_W-1:0]        rsp_rdata_o,
    output logic [NUM_BANKS-1:0]              bank_req_o,
    output logic [NUM_BANKS-1:0]              bank_we_o,
    output logic [NUM_BANKS*BANK_WORD_AW-1:0] bank_addr_o,
    output logic [NUM_BANKS*(DATA_W/8)-1:0]   bank_be_o,
    output logic [NUM_BANKS*DATA_W-1:0]       bank_wdata_o,
    input  logic [NUM_BANKS*DATA_W-1:0]       bank_rdata_i
);

    import data_ram_bank_xbar_pkg::*;

    localparam int BE_W = DATA_W / 8;

    dram_decode_t          dec_s      [NUM_REQS];
    logic [NUM_REQS-1:0]   in_range_s;
    logic [NUM_REQS-1:0]   bank_hit_s [NUM_BANKS];
    logic [NUM_REQS-1:0]   bank_gnt_s [NUM_BANKS];
    logic [NUM_REQS-1:0]   lane_gnt_s;

    logic [NUM_REQS-1:0]   rsp_valid_r;
    logic [NUM_REQS-1:0]   rsp_err_r;
    logic [NUM_REQS-1:0]   rsp_we_r;
    logic [BANK_IDX_W-1:0] rsp_bank_r [NUM_REQS];

    // Address decode per lane.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            dec_s[i]      = dram_decode(req_addr_i[i*32 +: 32]);
            in_range_s[i] = dec_s[i].in_range;
        end
    end

    // Per-bank request vectors; reset masks every request so no bank is
    // strobed and no lane is granted while reset is held.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                bank_hit_s[b][i] = !reset && req_valid_i[i] && in_range_s[i]
                                   && (dec_s[i].bank == BANK_IDX_W'(b));
            end
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank_arb
            data_ram_rr_arbiter #(
                .N (NUM_REQS)
            ) u_arb (
                .clk   (clk),
                .reset (reset),
                .req   (bank_hit_s[gb]),
                .gnt   (bank_gnt_s[gb])
            );
        end
    endgenerate

    // Lane acceptance: granted by its bank, or out of range (never waits).
    always_comb begin
        lane_gnt_s  = '0;
        req_ready_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            lane_gnt_s = lane_gnt_s | bank_gnt_s[b];
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready_o[i] = !reset && req_valid_i[i] && (!in_range_s[i] || lane_gnt_s[i]);
        end
    end

    // Bank port mux: grants are one-hot, so an AND-OR select is exact.
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_req_o[b] = |bank_gnt_s[b];
            for (int i = 0; i < NUM_REQS; i++) begin
                bank_we_o[b] = bank_we_o[b] | (bank_gnt_s[b][i] & req_we_i[i]);
                bank_addr_o[b*BANK_WORD_AW +: BANK_WORD_AW] =
                    bank_addr_o[b*BANK_WORD_AW +: BANK_WORD_AW]
                    | ({BANK_WORD_AW{bank_gnt_s[b][i]}} & dec_s[i].word);
                bank_be_o[b*BE_W +: BE_W] =
                    bank_be_o[b*BE_W +: BE_W]
                    | ({BE_W{bank_gnt_s[b][i]}} & req_be_i[i*BE_W +: BE_W]);
                bank_wdata_o[b*DATA_W +: DATA_W] =
                    bank_wdata_o[b*DATA_W +: DATA_W]
                    | ({DATA_W{bank_gnt_s[b][i]}} & req_wdata_i[i*DATA_W +: DATA_W]);
            end
        end
    end

    // Response bookkeeping captured on acceptance; reset drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= '0;
            rsp_err_r   <= '0;
            rsp_we_r    <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                rsp_bank_r[i] <= '0;
            end
        end else begin
            rsp_valid_r <= req_ready_o;
            rsp_err_r   <= req_ready_o & ~in_range_s;
            rsp_we_r    <= req_we_i;
            for (int i = 0; i < NUM_REQS; i++) begin
                rsp_bank_r[i] <= dec_s[i].bank;
            end
        end
    end

    // Read data return: route the captured bank's SRAM output, zero otherwise.
    always_comb begin
        rsp_valid_o = rsp_valid_r;
        rsp_err_o   = rsp_err_r;
        rsp_rdata_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_valid_r[i] && !rsp_err_r[i] && !rsp_we_r[i]) begin
                rsp_rdata_o[i*DATA_W +: DATA_W] = bank_rdata_i[rsp_bank_r[i]*DATA_W +: DATA_W];
            end else begin
                rsp_rdata_o[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule

// File: tb/tb_data_ram_bank_xbar.sv
// -----------------------------------------------------------------------------
// tb_data_ram_bank_xbar
// Self-checking bench: directed scenarios with literal expectations, then
// randomized lane traffic compared every cycle against a behavioural model
// (flat word memory, per-bank priority pointers, 1-cycle response queue).
// Bank SRAMs are modelled behaviourally and driven from the DUT's bank ports.
// -----------------------------------------------------------------------------
module tb_data_ram_bank_xbar;

    localparam int NR = 4;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 13;
    localparam int WORDS = 8192;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_we;
    logic [NR*32-1:0]  req_addr;
    logic [NR*4-1:0]   req_be;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready, rsp_valid, rsp_err;
    logic [NR*DW-1:0]  rsp_rdata;
    logic [NB-1:0]     bank_req, bank_we;
    logic [NB*AW-1:0]  bank_addr;
    logic [NB*4-1:0]   bank_be;
    logic [NB*DW-1:0]  bank_wdata;
    logic [NB*DW-1:0]  bank_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_ram_bank_xbar #(
        .NUM_REQS     (NR),
        .NUM_BANKS    (NB),
        .DATA_W       (DW),
        .BANK_WORD_AW (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_we_i     (req_we),
        .req_be_i     (req_be),
        .req_wdata_i  (req_wdata),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_err_o    (rsp_err),
        .rsp_rdata_o  (rsp_rdata),
        .bank_req_o   (bank_req),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_be_o    (bank_be),
        .bank_wdata_o (bank_wdata),
        .bank_rdata_i (bank_rdata)
    );

    // Behavioural bank SRAMs (cleared while reset is held so contents are known).
    logic [31:0] sram [NB][WORDS];
    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < WORDS; w++)
                    sram[b][w] <= 32'h0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_req[b]) begin
                    if (bank_we[b]) begin
                        for (int j = 0; j < 4; j++)
                            if (bank_be[b*4+j])
                                sram[b][bank_addr[b*AW +: AW]][j*8 +: 8] <= bank_wdata[b*DW + j*8 +: 8];
                    end else begin
                        bank_rdata[b*DW +: DW] <= sram[b][bank_addr[b*AW +: AW]];
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0]   ref_mem [NB*WORDS];
    int            ref_ptr [NB];
    logic [NR-1:0] exp_rv, exp_err;
    logic [31:0]   exp_rd [NR];
    logic [NR-1:0] last_ready;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'h0000_8000) && (a < 32'h0002_8000);
    endfunction
    function automatic int bank_of(input logic [31:0] a);
        return int'((a - 32'h0000_8000) / 32'h0000_8000);
    endfunction
    function automatic int word_of(input logic [31:0] a);
        return int'(((a - 32'h0000_8000) % 32'h0000_8000) / 32'd4);
    endfunction
    function automatic int flat_of(input logic [31:0] a);
        return int'((a - 32'h0000_8000) / 32'd4);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: compare all outputs against the model, then advance it.
    task automatic step();
        int            gl [NB];
        logic [NR-1:0] e_rdy;
        logic [NB-1:0] e_breq;
        logic [31:0]   a;
        int            l;
        @(negedge clk);
        if (reset) begin
            exp_rv  = '0;
            exp_err = '0;
            for (int i = 0; i < NR; i++) exp_rd[i] = 32'h0;
        end
        for (int i = 0; i < NR; i++) begin
            check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(exp_rv[i]));
            check($sformatf("rsp_err[%0d]", i), 64'(rsp_err[i]), 64'(exp_err[i]));
            check($sformatf("rsp_rdata[%0d]", i), 64'(rsp_rdata[i*DW +: DW]), 64'(exp_rd[i]));
        end
        e_rdy  = '0;
        e_breq = '0;
        for (int b = 0; b < NB; b++) gl[b] = -1;
        if (!reset) begin
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && !in_rng(req_addr[i*32 +: 32])) e_rdy[i] = 1'b1;
            for (int b = 0; b < NB; b++) begin
                for (int k = 0; k < NR; k++) begin
                    l = (ref_ptr[b] + k) % NR;
                    a = req_addr[l*32 +: 32];
                    if (gl[b] < 0 && req_valid[l] && in_rng(a) && bank_of(a) == b) gl[b] = l;
                end
                if (gl[b] >= 0) begin
                    l = gl[b];
                    e_rdy[l]  = 1'b1;
                    e_breq[b] = 1'b1;
                    check($sformatf("bank_we[%0d]", b), 64'(bank_we[b]), 64'(req_we[l]));
                    check($sformatf("bank_addr[%0d]", b), 64'(bank_addr[b*AW +: AW]),
                          64'(word_of(req_addr[l*32 +: 32])));
                    check($sformatf("bank_be[%0d]", b), 64'(bank_be[b*4 +: 4]), 64'(req_be[l*4 +: 4]));
                    check($sformatf("bank_wdata[%0d]", b), 64'(bank_wdata[b*DW +: DW]),
                          64'(req_wdata[l*DW +: DW]));
                end
            end
        end
        check("req_ready", 64'(req_ready), 64'(e_rdy));
        check("bank_req", 64'(bank_req), 64'(e_breq));
        last_ready = e_rdy;
        @(posedge clk);
        if (reset) begin
            exp_rv  = '0;
            exp_err = '0;
            for (int i = 0; i < NR; i++) exp_rd[i] = 32'h0;
            for (int b = 0; b < NB; b++) ref_ptr[b] = 0;
            for (int w = 0; w < NB*WORDS; w++) ref_mem[w] = 32'h0;
        end else begin
            // reads see memory before this cycle's writes (at most one access per bank)
            for (int i = 0; i < NR; i++) begin
                a          = req_addr[i*32 +: 32];
                exp_rv[i]  = e_rdy[i];
                exp_err[i] = e_rdy[i] && !in_rng(a);
                exp_rd[i]  = (e_rdy[i] && in_rng(a) && !req_we[i]) ? ref_mem[flat_of(a)] : 32'h0;
            end
            for (int b = 0; b < NB; b++) begin
                if (gl[b] >= 0) begin
                    l = gl[b];
                    a = req_addr[l*32 +: 32];
                    if (req_we[l])
                        for (int j = 0; j < 4; j++)
                            if (req_be[l*4+j]) ref_mem[flat_of(a)][j*8 +: 8] = req_wdata[l*DW + j*8 +: 8];
                    ref_ptr[b] = (l + 1) % NR;
                end
            end
        end
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*32 +: 32] = a;
        req_be[i*4 +: 4]     = be;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NR; i++) set_lane(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    logic [31:0] err_addrs [3];
    int          r;

    initial begin
        reset = 1'b1;
        clear_lanes();
        exp_rv     = '0;
        exp_err    = '0;
        last_ready = '0;
        for (int i = 0; i < NR; i++) exp_rd[i] = 32'h0;
        for (int b = 0; b < NB; b++) ref_ptr[b] = 0;
        for (int w = 0; w < NB*WORDS; w++) ref_mem[w] = 32'h0;

        // reset: nothing accepted, no strobes, no responses even with a request pending
        set_lane(0, 1'b1, 1'b0, 32'h0000_8000, 4'h0, 32'h0);
        step();
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_bank_req", 64'(bank_req), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        step();
        clear_lanes();
        reset = 1'b0;

        // write DEADBEEF to 0x8004 then read it back
        set_lane(0, 1'b1, 1'b1, 32'h0000_8004, 4'hF, 32'hDEAD_BEEF);
        #1;
        check("wr_bank_req", 64'(bank_req), 64'h1);
        check("wr_bank_addr", 64'(bank_addr[AW-1:0]), 64'h1);
        step();
        check("wr_rsp_valid", 64'(rsp_valid[0]), 64'h1);
        check("wr_rsp_rdata", 64'(rsp_rdata[31:0]), 64'h0);
        set_lane(0, 1'b1, 1'b0, 32'h0000_8004, 4'h0, 32'h0);
        step();
        clear_lanes();
        check("rd_rsp_rdata", 64'(rsp_rdata[31:0]), 64'hDEAD_BEEF);
        check("rd_rsp_err", 64'(rsp_err[0]), 64'h0);
        step();

        // four lanes to four banks in parallel
        set_lane(0, 1'b1, 1'b0, 32'h0000_8000, 4'h0, 32'h0);
        set_lane(1, 1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
        set_lane(2, 1'b1, 1'b0, 32'h0001_8000, 4'h0, 32'h0);
        set_lane(3, 1'b1, 1'b0, 32'h0002_0000, 4'h0, 32'h0);
        #1;
        check("par_ready", 64'(req_ready), 64'hF);
        check("par_bank_req", 64'(bank_req), 64'hF);
        step();
        clear_lanes();
        check("par_rsp_valid", 64'(rsp_valid), 64'hF);
        check("par_rsp_err", 64'(rsp_err), 64'h0);

        // reset right after an accepted read drops its response
        set_lane(1, 1'b1, 1'b0, 32'h0000_8000, 4'h0, 32'h0);
        step();
        clear_lanes();
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        step();
        step();
        reset = 1'b0;

        // all four lanes contend for bank 2: pointers reset to 0 -> lanes 0,1,2,3
        for (int i = 0; i < NR; i++)
            set_lane(i, 1'b1, 1'b0, 32'h0001_8000 + 32'(i*4), 4'h0, 32'h0);
        for (int c = 0; c < NR; c++) begin
            #1;
            check($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(4'b0001 << c));
            check($sformatf("rr_bank_req_c%0d", c), 64'(bank_req), 64'h4);
            step();
            req_valid[c] = 1'b0;
        end
        step();

        // out-of-range addresses: immediate accept, error response, no bank access
        err_addrs[0] = 32'h0002_8000;
        err_addrs[1] = 32'h0000_0000;
        err_addrs[2] = 32'h0000_7FFC;
        for (int e = 0; e < 3; e++) begin
            set_lane(1, 1'b1, 1'b0, err_addrs[e], 4'h0, 32'h0);
            #1;
            check($sformatf("err%0d_ready", e), 64'(req_ready), 64'h2);
            check($sformatf("err%0d_bank_req", e), 64'(bank_req), 64'h0);
            step();
            clear_lanes();
            check($sformatf("err%0d_rsp_err", e), 64'(rsp_err[1]), 64'h1);
            check($sformatf("err%0d_rsp_rdata", e), 64'(rsp_rdata[DW +: DW]), 64'h0);
        end

        // last valid word of the map
        set_lane(3, 1'b1, 1'b1, 32'h0002_7FFC, 4'hF, 32'h1234_5678);
        #1;
        check("top_bank_req", 64'(bank_req), 64'h8);
        check("top_bank_addr", 64'(bank_addr[3*AW +: AW]), 64'h1FFF);
        step();
        clear_lanes();
        check("top_rsp_err", 64'(rsp_err[3]), 64'h0);
        step();

        // randomized traffic; lanes hold a request until accepted
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || last_ready[i]) begin
                    r = int'($urandom_range(0, 15));
                    if (r == 0)
                        req_addr[i*32 +: 32] = 32'h0002_8000;
                    else if (r == 1)
                        req_addr[i*32 +: 32] = 32'h0000_7FFC;
                    else if (r == 2)
                        req_addr[i*32 +: 32] = 32'h0002_7FFC;
                    else
                        req_addr[i*32 +: 32] = 32'h0000_8000 + 32'($urandom_range(0, 3)) * 32'h8000
                                               + 32'($urandom_range(0, 7)) * 32'd4
                                               + 32'($urandom_range(0, 3));
                    req_valid[i]          = ($urandom_range(0, 3) != 0);
                    req_we[i]             = 1'($urandom_range(0, 1));
                    req_be[i*4 +: 4]      = 4'($urandom_range(0, 15));
                    req_wdata[i*DW +: DW] = $urandom;
                end
            end
            step();
        end
        reset = 1'b0;
        clear_lanes();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
